// File: rtl/regbank_mp_if.sv
// Bus bundle for regbank_mp: write port, reserve port, clear request, and two read ports.
// Latency: none; this file only groups signals.
// Backpressure: none on the bus itself; the bank reports busy and drops requests while it sweeps.
// Ports (master = bank user, slave = bank):
//   master drives wen/wsel/in, rsel_a/rsel_b, rsv/rsv_sel, clr
//   slave drives out_a/out_b, pend_a/pend_b, busy, done
interface regbank_mp_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 3
);
  logic             wen;
  logic [AW-1:0]    wsel;
  logic [WIDTH-1:0] in;
  logic [AW-1:0]    rsel_a;
  logic [AW-1:0]    rsel_b;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic             pend_a;
  logic             pend_b;
  logic             rsv;
  logic [AW-1:0]    rsv_sel;
  logic             clr;
  logic             busy;
  logic             done;

  modport master (
    output wen, wsel, in, rsel_a, rsel_b, rsv, rsv_sel, clr,
    input  out_a, out_b, pend_a, pend_b, busy, done
  );

  modport slave (
    input  wen, wsel, in, rsel_a, rsel_b, rsv, rsv_sel, clr,
    output out_a, out_b, pend_a, pend_b, busy, done
  );
endinterface

// File: rtl/regbank_mp.sv
// Multi-port register bank with per-register pending bits and a sequenced clear sweep.
// Latency: writes/reserves land on the next edge; reads are combinational; a sweep takes 2**AW cycles.
// Backpressure: while busy, wen/rsv/clr are dropped (not queued); reads stay live.
// Ports: clk, reset (synchronous, active-high), bus (regbank_mp_if.slave).
// Optional feature: define REGBANK_MP_BYPASS_EN for same-cycle write-to-read forwarding.
module regbank_mp #(
  parameter int WIDTH = 16,
  parameter int AW    = 3
) (
  input  logic         clk,
  input  logic         reset,
  regbank_mp_if.slave  bus
);
  localparam int DEPTH = 2 ** AW;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0] pend_q;
  logic             busy;
  logic             done;
  logic             wr_ok;
  logic             rsv_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // busy/done decode only from state flops, so no input reaches them combinationally.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.clr) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        busy  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        // Terminal compare rather than counter wrap keeps DEPTH=2 correct.
        if (cnt_q == {AW{1'b1}}) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_ok  = bus.wen && !busy;
  assign rsv_ok = bus.rsv && !busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      pend_q <= '0;
    end else begin
      if (busy) begin
        regs_q[cnt_q] <= '0;
        pend_q[cnt_q] <= 1'b0;
      end
      if (wr_ok) begin
        regs_q[bus.wsel] <= bus.in;
        pend_q[bus.wsel] <= 1'b0;
      end
      // Ordered after the write so a same-address reserve leaves the bit set.
      if (rsv_ok) begin
        pend_q[bus.rsv_sel] <= 1'b1;
      end
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;

`ifdef REGBANK_MP_BYPASS_EN
  logic fwd_a, fwd_b, rsv_hit;

  assign fwd_a   = wr_ok && (bus.wsel == bus.rsel_a);
  assign fwd_b   = wr_ok && (bus.wsel == bus.rsel_b);
  // A same-cycle reserve on the written address means the pending bit will not
  // clear, so the forwarded flag falls back to the stored value.
  assign rsv_hit = bus.rsv && (bus.rsv_sel == bus.wsel);

  assign bus.out_a  = fwd_a ? bus.in : regs_q[bus.rsel_a];
  assign bus.out_b  = fwd_b ? bus.in : regs_q[bus.rsel_b];
  assign bus.pend_a = (fwd_a && !rsv_hit) ? 1'b0 : pend_q[bus.rsel_a];
  assign bus.pend_b = (fwd_b && !rsv_hit) ? 1'b0 : pend_q[bus.rsel_b];
`else
  assign bus.out_a  = regs_q[bus.rsel_a];
  assign bus.out_b  = regs_q[bus.rsel_b];
  assign bus.pend_a = pend_q[bus.rsel_a];
  assign bus.pend_b = pend_q[bus.rsel_b];
`endif
endmodule

// File: tb/tb_regbank_mp.sv
// Bench for regbank_mp: directed steps from the test plan plus randomized traffic,
// all outputs compared each step against a cycle-indexed reference model.
// A second instance (WIDTH=32, AW=4) covers the wider/deeper configuration.
module tb_regbank_mp;
  localparam int DEPTH = 8;

  logic clk;
  logic reset;

  regbank_mp_if #(.WIDTH(16), .AW(3)) bus  ();
  regbank_mp_if #(.WIDTH(32), .AW(4)) bus2 ();

  regbank_mp #(.WIDTH(16), .AW(3)) dut  (.clk(clk), .reset(reset), .bus(bus));
  regbank_mp #(.WIDTH(32), .AW(4)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ncomp = 0;
  int nfail = 0;

  // Reference model: contents plus the edge index at which the last clear was accepted.
  logic [15:0] mreg  [DEPTH];
  bit          mpend [DEPTH];
  int          sweep_n = -1;
  int          cyc = 0;

  function automatic bit mbusy();
    return (sweep_n >= 0) && (cyc >= sweep_n) && (cyc - sweep_n <= DEPTH - 1);
  endfunction

  function automatic bit mdone();
    return mbusy() && (cyc - sweep_n == DEPTH - 1);
  endfunction

  function automatic logic [15:0] exp_out(logic [2:0] rs);
`ifdef REGBANK_MP_BYPASS_EN
    if (bus.wen && !mbusy() && bus.wsel == rs) return bus.in;
`endif
    return mreg[rs];
  endfunction

  function automatic logic exp_pend(logic [2:0] rs);
`ifdef REGBANK_MP_BYPASS_EN
    if (bus.wen && !mbusy() && bus.wsel == rs && !(bus.rsv && bus.rsv_sel == bus.wsel)) return 1'b0;
`endif
    return mpend[rs];
  endfunction

  // Advance the model by one edge using the inputs currently applied.
  task automatic model_step();
    int e;
    e = cyc + 1;
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mreg[i]  = '0;
        mpend[i] = 1'b0;
      end
      sweep_n = -1;
    end else if (!mbusy()) begin
      if (bus.wen) begin
        mreg[bus.wsel]  = bus.in;
        mpend[bus.wsel] = 1'b0;
      end
      if (bus.rsv) mpend[bus.rsv_sel] = 1'b1;
      if (bus.clr) sweep_n = e;
    end else begin
      mreg[e - sweep_n - 1]  = '0;
      mpend[e - sweep_n - 1] = 1'b0;
    end
    cyc = e;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("out_a",  32'(bus.out_a),  32'(exp_out(bus.rsel_a)));
    chk("out_b",  32'(bus.out_b),  32'(exp_out(bus.rsel_b)));
    chk("pend_a", 32'(bus.pend_a), 32'(exp_pend(bus.rsel_a)));
    chk("pend_b", 32'(bus.pend_b), 32'(exp_pend(bus.rsel_b)));
    chk("busy",   32'(bus.busy),   32'(mbusy()));
    chk("done",   32'(bus.done),   32'(mdone()));
  endtask

  task automatic step();
    #1;
    check_all();
    tick();
  endtask

  task automatic idle_inputs();
    bus.wen = 1'b0; bus.wsel = '0; bus.in = '0;
    bus.rsv = 1'b0; bus.rsv_sel = '0; bus.clr = 1'b0;
  endtask

  task automatic check_all_zero(string tag);
    for (int i = 0; i < DEPTH; i++) begin
      bus.rsel_a = 3'(i);
      bus.rsel_b = 3'(DEPTH - 1 - i);
      #1;
      chk({tag, "_out"},  32'(bus.out_a),  32'h0);
      chk({tag, "_pend"}, 32'(bus.pend_b), 32'h0);
    end
  endtask

  initial begin
    int nb;
    int nd;

    idle_inputs();
    bus.rsel_a = '0; bus.rsel_b = '0;
    bus2.wen = 1'b0; bus2.wsel = '0; bus2.in = '0; bus2.rsel_a = '0; bus2.rsel_b = '0;
    bus2.rsv = 1'b0; bus2.rsv_sel = '0; bus2.clr = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Reset state
    #1;
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    check_all_zero("rst");

    // Reset then write
    bus.wen = 1'b1; bus.wsel = 3'd3; bus.in = 16'h1234; step();
    bus.wsel = 3'd7; bus.in = 16'hBEEF; step();
    idle_inputs();
    bus.rsel_a = 3'd3; bus.rsel_b = 3'd7; #1;
    chk("rd_r3", 32'(bus.out_a), 32'h1234);
    chk("rd_r7", 32'(bus.out_b), 32'hBEEF);
    for (int i = 0; i < DEPTH; i++) begin
      if (i != 3 && i != 7) begin
        bus.rsel_a = 3'(i); #1;
        chk("rd_other", 32'(bus.out_a), 32'h0);
      end
    end
    step();

    // Scoreboard
    bus.rsv = 1'b1; bus.rsv_sel = 3'd5; bus.rsel_a = 3'd5; step();
    idle_inputs(); #1;
    chk("rsv_pend", 32'(bus.pend_a), 32'h1);
    bus.wen = 1'b1; bus.wsel = 3'd5; bus.in = 16'h00AA; step();
    idle_inputs(); #1;
    chk("wr_clr_pend", 32'(bus.pend_a), 32'h0);
    chk("wr_data",     32'(bus.out_a),  32'h00AA);
    bus.wen = 1'b1; bus.wsel = 3'd2; bus.in = 16'h5555;
    bus.rsv = 1'b1; bus.rsv_sel = 3'd2; bus.rsel_b = 3'd2; step();
    idle_inputs(); #1;
    chk("wr_rsv_data", 32'(bus.out_b),  32'h5555);
    chk("wr_rsv_pend", 32'(bus.pend_b), 32'h1);

    // Clear sweep: preload all with FFFF, r1 pending
    for (int i = 0; i < DEPTH; i++) begin
      bus.wen = 1'b1; bus.wsel = 3'(i); bus.in = 16'hFFFF; step();
    end
    idle_inputs();
    bus.rsv = 1'b1; bus.rsv_sel = 3'd1; step();
    idle_inputs();
    bus.clr = 1'b1; step();
    bus.clr = 1'b0;
    nb = 0; nd = 0;
    for (int i = 0; i < 12; i++) begin
      bus.wen = (i == 0); bus.wsel = 3'd0; bus.in = 16'h7777;
      bus.rsel_a = 3'(i); bus.rsel_b = 3'($urandom_range(0, DEPTH - 1));
      #1;
      if (bus.busy) nb++;
      if (bus.done) nd++;
      check_all();
      tick();
    end
    idle_inputs();
    chk("sweep_len",  32'(nb), 32'd8);
    chk("sweep_done", 32'(nd), 32'd1);
    check_all_zero("swept");

    // Reset mid-sweep
    bus.wen = 1'b1; bus.wsel = 3'd6; bus.in = 16'h4242; step();
    idle_inputs();
    bus.clr = 1'b1; step();
    bus.clr = 1'b0;
    for (int i = 0; i < 3; i++) step();
    reset = 1'b1; tick();
    reset = 1'b0;
    #1;
    chk("mid_busy", 32'(bus.busy), 32'h0);
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (bus.done) nd++;
      check_all();
      tick();
    end
    chk("mid_no_done", 32'(nd), 32'd0);
    check_all_zero("mid");

    // Write forwarding
    bus.wen = 1'b1; bus.wsel = 3'd4; bus.in = 16'h1111; step();
    bus.in = 16'hCAFE; bus.rsel_a = 3'd4; #1;
`ifdef REGBANK_MP_BYPASS_EN
    chk("byp_same", 32'(bus.out_a), 32'hCAFE);
`else
    chk("byp_same", 32'(bus.out_a), 32'h1111);
`endif
    step();
    idle_inputs(); #1;
    chk("byp_after", 32'(bus.out_a), 32'hCAFE);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bus.wen     = 1'($urandom_range(0, 1));
      bus.wsel    = 3'($urandom_range(0, DEPTH - 1));
      bus.in      = 16'($urandom);
      bus.rsv     = ($urandom_range(0, 3) == 0);
      bus.rsv_sel = ($urandom_range(0, 1) == 0) ? bus.wsel : 3'($urandom_range(0, DEPTH - 1));
      bus.clr     = ($urandom_range(0, 24) == 0);
      bus.rsel_a  = ($urandom_range(0, 2) == 0) ? bus.wsel : 3'($urandom_range(0, DEPTH - 1));
      bus.rsel_b  = 3'($urandom_range(0, DEPTH - 1));
      step();
    end
    idle_inputs();
    for (int i = 0; i < DEPTH + 1; i++) step();

    // Parametric instance: WIDTH=32, AW=4
    bus2.wen = 1'b1; bus2.wsel = 4'd15; bus2.in = 32'hDEADBEEF; tick();
    bus2.wen = 1'b0; bus2.rsel_a = 4'd15; #1;
    chk("p_rd_r15", bus2.out_a, 32'hDEADBEEF);
    bus2.clr = 1'b1; tick();
    bus2.clr = 1'b0;
    nb = 0; nd = 0;
    for (int i = 0; i < 40 && (i == 0 || bus2.busy); i++) begin
      #1;
      if (bus2.busy) nb++;
      if (bus2.done) nd++;
      tick();
    end
    chk("p_sweep_len",  32'(nb), 32'd16);
    chk("p_sweep_done", 32'(nd), 32'd1);
    #1;
    chk("p_swept_r15", bus2.out_a, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end
endmodule
